mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported, variable-latency unified memory between the pipeline's
//  fetch requester (F stage, read-only) and data requester (M stage, load/store).
//  Sits between pipeline_proc and the memory, replacing the split imem/dmem pair.
//  Generates stall_f/stall_m for the hazard unit.
//  Only one memory transaction is outstanding at a time; read data is returned registered.
// PARAMETERS
//  AW            32   byte-address width; mem_addr_o = {addr[AW-1:2],2'b00}
//  DW            32   data width
//  MAX_DATA_RUN  4    consecutive data grants allowed while fetch waits, then fetch wins once
//  TIMEOUT       255  cycles in BUSY without mem_ready_i before abort + err_o
// PORTS
//  clk_i          in   1   clock, rising edge
//  reset_n_i      in   1   asynchronous, active-low reset
//  fetch_req_i    in   1   fetch request; held with fetch_addr_i stable until fetch_done_o
//  fetch_addr_i   in   AW  instruction byte address (pc_f)
//  fetch_done_o   out  1   1-cycle pulse: fetch_rdata_o valid
//  fetch_rdata_o  out  DW  instruction word
//  data_req_i     in   1   data request; held with addr/we/wdata stable until data_done_o
//  data_we_i      in   1   1=store, 0=load
//  data_addr_i    in   AW  data byte address (aluout_m)
//  data_wdata_i   in   DW  store data (writedata_m)
//  data_done_o    out  1   1-cycle pulse: store committed / data_rdata_o valid
//  data_rdata_o   out  DW  load data
//  stall_f_o      out  1   fetch_req_i & ~fetch_done_o
//  stall_m_o      out  1   data_req_i & ~data_done_o
//  mem_req_o      out  1   memory request; high for the whole BUSY state
//  mem_we_o       out  1   write enable for the current transaction
//  mem_addr_o     out  AW  word-aligned address
//  mem_wdata_o    out  DW  write data
//  mem_rdata_i    in   DW  read data, valid when mem_ready_i=1
//  mem_ready_i    in   1   transaction complete this cycle
//  err_o          out  1   sticky timeout flag; cleared only by reset
// BEHAVIOUR
//  Reset: state=IDLE; all outputs, the owner bit, the run count and the timeout count = 0.
//   Reset mid-BUSY aborts immediately: mem_req_o falls asynchronously, and no done pulse is issued.
//  FSM: IDLE -> BUSY on any request (grant latched at the edge); BUSY -> RESP on mem_ready_i;
//   RESP -> IDLE unconditionally. Min latency: req at edge n -> done high during cycle n+2
//   (ready in first BUSY cycle).
//  mem_addr_o/mem_we_o/mem_wdata_o are registered at grant and held constant through BUSY.
//  RESP: the owner's done=1 for exactly 1 cycle. For a data load, data_rdata_o = mem_rdata_i
//   captured at the ready edge; rdata regs hold their value until the next capture.
//  Arbitration in IDLE, both requesting: data wins (older instruction) unless
//   run_cnt==MAX_DATA_RUN, in which case fetch wins.
//   run_cnt increments on a data grant while fetch_req_i=1, clears on a fetch grant,
//   and saturates at MAX_DATA_RUN.
//  Requests are not accepted in RESP (1 idle bubble); a request dropped while in IDLE is ignored.
//  Timeout: a counter runs in BUSY; when it reaches TIMEOUT without ready: ->IDLE, err_o=1,
//   and the owner's done pulses with rdata=0 so the pipeline does not deadlock.
//  mem_ready_i outside BUSY is ignored.
//  stall_* are combinational from the inputs and the registered done; there is no path
//   from mem_* inputs to stall.
// STRUCTURE
//  Package mips_mem_pkg: typedef enum logic[1:0] {ARB_IDLE,ARB_BUSY,ARB_RESP} arb_state_t;
//   typedef enum logic {OWN_FETCH,OWN_DATA} arb_owner_t.
//  Sub-module mem_arb_watchdog (load/clear, count, hit flag) for the timeout counter;
//   FSM and run counter inline.
// TESTING
//  1 Fetch only, ready in the 1st BUSY cycle, addr 0x0000_0044 -> mem_addr_o=0x44,
//    fetch_done_o at cycle+2, rdata=mem value, stall_f high for 2 cycles.
//  2 Fetch+load on the same edge, run_cnt=0 -> data granted first. Fetch granted
//    after RESP. data_done precedes fetch_done by >=3 cycles.
//  3 Fetch held, data_req continuous -> after 4 data grants the 5th grant is fetch; run_cnt->0.
//  4 Store 0xDEAD_BEEF @0x80, ready delayed 5 cycles -> mem_we_o=1 and fields stable
//    for 6 BUSY cycles, data_done 1 pulse.
//  5 mem_ready_i never asserted -> after 255 BUSY cycles err_o=1, done pulses with rdata=0,
//    and the next request proceeds normally.
//  6 reset_n_i low mid-BUSY -> mem_req_o=0 in the same cycle, no done; state IDLE after release.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared types and arbitration helper for the unified memory port
package mips_mem_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_RESP} arb_state_t;
  typedef enum logic {OWN_FETCH, OWN_DATA} arb_owner_t;
  function automatic arb_owner_t arb_pick(input logic fetch, input logic data, input logic run_full);
    return (data && !(fetch && run_full)) ? OWN_DATA : OWN_FETCH;
  endfunction
endpackage

// File: rtl/mem_arb_watchdog.sv
// mem_arb_watchdog: counts busy cycles and flags the last cycle before a timeout abort
module mem_arb_watchdog #(
  parameter int LIMIT = 255
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_o
);
  localparam int CW = $clog2(LIMIT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign cnt_d = clr_i ? '0 : en_i ? cnt_q + CW'(1) : cnt_q;
  assign hit_o = cnt_q == CW'(LIMIT - 1);
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one variable-latency memory between fetch and data requesters
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int MAX_DATA_RUN = 4,
  parameter int TIMEOUT = 255
) (
  input  logic          clk_i,
  input  logic          reset_n_i,
  input  logic          fetch_req_i,
  input  logic [AW-1:0] fetch_addr_i,
  output logic          fetch_done_o,
  output logic [DW-1:0] fetch_rdata_o,
  input  logic          data_req_i,
  input  logic          data_we_i,
  input  logic [AW-1:0] data_addr_i,
  input  logic [DW-1:0] data_wdata_i,
  output logic          data_done_o,
  output logic [DW-1:0] data_rdata_o,
  output logic          stall_f_o,
  output logic          stall_m_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic          mem_ready_i,
  output logic          err_o
);
  localparam int RW = $clog2(MAX_DATA_RUN + 1);
  arb_state_t state_q, state_d;
  arb_owner_t owner_q, owner_d, pick;
  logic [RW-1:0] run_q, run_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d, frd_q, frd_d, drd_q, drd_d;
  logic we_q, we_d, fdone_q, fdone_d, ddone_q, ddone_d, err_q, err_d;
  logic busy, ready, hit, wd_hit, grant, run_full;
  assign busy = state_q == ARB_BUSY;
  assign ready = busy && mem_ready_i;
  assign hit = busy && !mem_ready_i && wd_hit;
  assign run_full = run_q == RW'(MAX_DATA_RUN);
  assign pick = arb_pick(fetch_req_i, data_req_i, run_full);
  // a timeout done pulse lands in IDLE while its request is still held; do not re-grant it
  assign grant = state_q == ARB_IDLE && (fetch_req_i || data_req_i) && !fdone_q && !ddone_q;
  mem_arb_watchdog #(.LIMIT(TIMEOUT)) u_wd (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .clr_i    (!busy),
    .en_i     (busy),
    .hit_o    (wd_hit)
  );
  always_comb begin
    state_d = state_q == ARB_RESP ? ARB_IDLE : state_q;
    owner_d = owner_q;
    run_d = run_q;
    addr_d = addr_q;
    we_d = we_q;
    wdata_d = wdata_q;
    frd_d = frd_q;
    drd_d = drd_q;
    fdone_d = 1'b0;
    ddone_d = 1'b0;
    err_d = err_q || hit;
    if (grant) begin
      state_d = ARB_BUSY;
      owner_d = pick;
      addr_d = (pick == OWN_DATA ? data_addr_i : fetch_addr_i) & ~AW'(3);
      we_d = pick == OWN_DATA && data_we_i;
      wdata_d = pick == OWN_DATA ? data_wdata_i : '0;
      run_d = pick == OWN_FETCH ? '0 : (fetch_req_i && !run_full) ? run_q + RW'(1) : run_q;
    end
    if (ready || hit) begin
      state_d = ready ? ARB_RESP : ARB_IDLE;
      fdone_d = owner_q == OWN_FETCH;
      ddone_d = owner_q == OWN_DATA;
      frd_d = owner_q == OWN_FETCH ? (ready ? mem_rdata_i : '0) : frd_q;
      drd_d = (owner_q == OWN_DATA && (hit || !we_q)) ? (ready ? mem_rdata_i : '0) : drd_q;
    end
  end
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      state_q <= ARB_IDLE;
      owner_q <= OWN_FETCH;
      run_q <= '0;
      addr_q <= '0;
      we_q <= 1'b0;
      wdata_q <= '0;
      frd_q <= '0;
      drd_q <= '0;
      fdone_q <= 1'b0;
      ddone_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      run_q <= run_d;
      addr_q <= addr_d;
      we_q <= we_d;
      wdata_q <= wdata_d;
      frd_q <= frd_d;
      drd_q <= drd_d;
      fdone_q <= fdone_d;
      ddone_q <= ddone_d;
      err_q <= err_d;
    end
  assign mem_req_o = busy;
  assign mem_we_o = we_q;
  assign mem_addr_o = addr_q;
  assign mem_wdata_o = wdata_q;
  assign fetch_done_o = fdone_q;
  assign data_done_o = ddone_q;
  assign fetch_rdata_o = frd_q;
  assign data_rdata_o = drd_q;
  assign stall_f_o = fetch_req_i && !fdone_q;
  assign stall_m_o = data_req_i && !ddone_q;
  assign err_o = err_q;
endmodule
